// File: rtl/scmp_op_encoder.sv
`default_nettype none
// ============================================================================
// Module   : scmp_op_encoder
// Purpose  : Turns a symbolic SC/MP instruction request (class, operation,
//            pointer, address mode, displacement) into the one- or two-byte
//            opcode stream consumed by the opcode decoder. Requests that
//            would land on a reserved or non-existent encoding are accepted,
//            flagged on err for one cycle, and produce no output bytes.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready, req_class[3:0], req_sub[2:0],
//            req_mode[1:0], req_ptr[1:0], req_disp[7:0]  - request side
//            out_valid/out_ready, out_data[7:0], out_last - byte stream side
//            err        - one-cycle pulse after an illegal request
//            insn_count - completed instructions, wraps at 256
// Revision : 1.0 - initial release
// ============================================================================
module scmp_op_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_class,
  input  logic [2:0] req_sub,
  input  logic [1:0] req_mode,
  input  logic [1:0] req_ptr,
  input  logic [7:0] req_disp,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err,
  output logic [7:0] insn_count
);

  localparam logic [3:0] C_CLS_MEM  = 4'd0;
  localparam logic [3:0] C_CLS_EXT  = 4'd1;
  localparam logic [3:0] C_CLS_ILD  = 4'd2;
  localparam logic [3:0] C_CLS_DLD  = 4'd3;
  localparam logic [3:0] C_CLS_JMP  = 4'd4;
  localparam logic [3:0] C_CLS_XPAL = 4'd5;
  localparam logic [3:0] C_CLS_XPAH = 4'd6;
  localparam logic [3:0] C_CLS_XAE  = 4'd7;
  localparam logic [3:0] C_CLS_CL   = 4'd8;
  localparam logic [2:0] C_OP_ST    = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPC  = 2'd1,
    S_DISP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_opc;
  logic [7:0] r_disp;
  logic       r_two;
  logic       r_err;
  logic [7:0] r_count;

  logic [7:0] w_opc;
  logic       w_two;
  logic       w_illegal;
  logic       w_accept;

  // Request decode: opcode, length and legality of the presented request.
  always_comb begin
    w_opc     = 8'h00;
    w_two     = 1'b0;
    w_illegal = 1'b0;
    case (req_class)
      C_CLS_MEM: begin
        w_two = 1'b1;
        case (req_mode)
          2'd0: w_opc = {2'b11, req_sub, 1'b0, req_ptr};
          2'd1: begin
            // Auto-indexed through P0 (the PC) has no valid encoding.
            w_opc     = {2'b11, req_sub, 1'b1, req_ptr};
            w_illegal = (req_ptr == 2'd0);
          end
          2'd2: begin
            // Immediate form borrows the m=1/pp=00 slot; store-immediate is
            // meaningless (0xCC).
            w_opc     = {2'b11, req_sub, 3'b100};
            w_illegal = (req_sub == C_OP_ST);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      C_CLS_EXT: begin
        w_opc     = {2'b01, req_sub, 3'b000};
        w_illegal = (req_sub == C_OP_ST);
      end
      C_CLS_ILD: begin
        w_opc = {6'b101010, req_ptr};
        w_two = 1'b1;
      end
      C_CLS_DLD: begin
        w_opc = {6'b101110, req_ptr};
        w_two = 1'b1;
      end
      C_CLS_JMP: begin
        w_opc = {4'b1001, req_sub[1:0], req_ptr};
        w_two = 1'b1;
      end
      C_CLS_XPAL: w_opc = {6'b001100, req_ptr};
      C_CLS_XPAH: w_opc = {6'b001101, req_ptr};
      C_CLS_XAE:  w_opc = 8'h01;
      C_CLS_CL:   w_opc = {7'b0000001, req_sub[0]};
      default:    w_illegal = 1'b1;
    endcase
  end

  assign w_accept = req_valid && req_ready;

  // Next state and stream outputs; outputs depend only on registered state,
  // so out_ready never reaches out_data combinationally.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept && !w_illegal) begin
          w_next = S_OPC;
        end
      end
      S_OPC: begin
        out_valid = 1'b1;
        out_data  = r_opc;
        out_last  = !r_two;
        if (out_ready) begin
          w_next = r_two ? S_DISP : S_IDLE;
        end
      end
      S_DISP: begin
        out_valid = 1'b1;
        out_data  = r_disp;
        out_last  = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_opc   <= 8'h00;
      r_disp  <= 8'h00;
      r_two   <= 1'b0;
      r_err   <= 1'b0;
      r_count <= 8'h00;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && w_illegal;
      if (w_accept && !w_illegal) begin
        r_opc  <= w_opc;
        r_disp <= req_disp;
        r_two  <= w_two;
      end
      if (out_valid && out_ready && out_last) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign err        = r_err;
  assign insn_count = r_count;

endmodule
`default_nettype wire
